// File: rtl/jamma_joy_scan.sv
// JAMMA control scanner: drives jselect, time-multiplexes the shared joystick
// bus into player 1 / player 2, synchronises and debounces every control line.
module jamma_joy_scan #(
    parameter int unsigned SETTLE      = 4,
    parameter int unsigned DEB_SAMPLES = 3
) (
    input  logic       pclk,
    input  logic       reset,
    input  logic [7:0] jjoy,
    input  logic [1:0] jcoin,
    input  logic       jservice,
    input  logic       jtest,
    input  logic [5:0] kbd_joy,
    output logic       jselect,
    output logic [7:0] joystick1,
    output logic [7:0] joystick2,
    output logic [1:0] coin,
    output logic       service,
    output logic       test,
    output logic       scan_tick
);

    localparam int unsigned CNT_W = 8;
    localparam int unsigned DEB_W = 4;
    localparam int unsigned P1_N  = 8;
    localparam int unsigned P2_N  = 12;

    typedef enum logic [1:0] {
        S1 = 2'd0,
        P1 = 2'd1,
        S2 = 2'd2,
        P2 = 2'd3
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   settle_cnt;

    logic [7:0]         jjoy_m, jjoy_s;
    logic [1:0]         jcoin_m, jcoin_s;
    logic               jservice_m, jservice_s;
    logic               jtest_m, jtest_s;

    logic [P1_N-1:0]             p1_q;
    logic [P1_N-1:0][DEB_W-1:0]  p1_cnt;
    logic [P2_N-1:0]             p2_q;
    logic [P2_N-1:0][DEB_W-1:0]  p2_cnt;

    logic [P1_N-1:0]    p1_samp;
    logic [P2_N-1:0]    p2_samp;

    // One debounce step: returns {next output, next counter}.
    function automatic logic [DEB_W:0] deb_step(input logic samp, input logic q,
                                                input logic [DEB_W-1:0] cnt);
        logic [DEB_W:0] r;
        r = {q, DEB_W'(0)};
        if (samp != q) begin
            if (cnt == DEB_W'(DEB_SAMPLES - 1))
                r = {samp, DEB_W'(0)};
            else
                r = {q, cnt + DEB_W'(1)};
        end
        return r;
    endfunction

    // Two-flop synchronisers for the asynchronous pin inputs (idle high).
    always_ff @(posedge pclk) begin
        if (reset) begin
            jjoy_m     <= '1;
            jjoy_s     <= '1;
            jcoin_m    <= '1;
            jcoin_s    <= '1;
            jservice_m <= 1'b1;
            jservice_s <= 1'b1;
            jtest_m    <= 1'b1;
            jtest_s    <= 1'b1;
        end else begin
            jjoy_m     <= jjoy;
            jjoy_s     <= jjoy_m;
            jcoin_m    <= jcoin;
            jcoin_s    <= jcoin_m;
            jservice_m <= jservice;
            jservice_s <= jservice_m;
            jtest_m    <= jtest;
            jtest_s    <= jtest_m;
        end
    end

    // Scan sequencer: settle/sample per player, registered jselect and tick.
    always_ff @(posedge pclk) begin
        if (reset) begin
            state      <= S1;
            settle_cnt <= '0;
            jselect    <= 1'b0;
            scan_tick  <= 1'b0;
        end else begin
            scan_tick <= (state == P2);
            unique case (state)
                S1: begin
                    if (settle_cnt == CNT_W'(SETTLE - 1)) begin
                        settle_cnt <= '0;
                        state      <= P1;
                    end else begin
                        settle_cnt <= settle_cnt + CNT_W'(1);
                    end
                end
                P1: begin
                    state   <= S2;
                    jselect <= 1'b1;
                end
                S2: begin
                    if (settle_cnt == CNT_W'(SETTLE - 1)) begin
                        settle_cnt <= '0;
                        state      <= P2;
                    end else begin
                        settle_cnt <= settle_cnt + CNT_W'(1);
                    end
                end
                P2: begin
                    state   <= S1;
                    jselect <= 1'b0;
                end
                default: begin
                    state      <= S1;
                    settle_cnt <= '0;
                    jselect    <= 1'b0;
                end
            endcase
        end
    end

    // Keyboard only reaches the player-1 direction/button bits 5:0.
    assign p1_samp = jjoy_s & {2'b11, kbd_joy};
    assign p2_samp = {jtest_s, jservice_s, jcoin_s, jjoy_s};

    // Player-1 debounce cells, updated on the P1 sample cycle.
    always_ff @(posedge pclk) begin
        if (reset) begin
            p1_q   <= '1;
            p1_cnt <= '0;
        end else if (state == P1) begin
            for (int i = 0; i < int'(P1_N); i++) begin
                {p1_q[i], p1_cnt[i]} <= deb_step(p1_samp[i], p1_q[i], p1_cnt[i]);
            end
        end
    end

    // Player-2 and coin/service/test debounce cells, updated on the P2 sample cycle.
    always_ff @(posedge pclk) begin
        if (reset) begin
            p2_q   <= '1;
            p2_cnt <= '0;
        end else if (state == P2) begin
            for (int i = 0; i < int'(P2_N); i++) begin
                {p2_q[i], p2_cnt[i]} <= deb_step(p2_samp[i], p2_q[i], p2_cnt[i]);
            end
        end
    end

    assign joystick1 = p1_q;
    assign joystick2 = p2_q[7:0];
    assign coin      = p2_q[9:8];
    assign service   = p2_q[10];
    assign test      = p2_q[11];

endmodule

// File: tb/tb_jamma_joy_scan.sv
// Scoreboard bench for jamma_joy_scan: the external mux is modelled from
// jselect, a per-scan reference model predicts the debounced outputs.
module tb_jamma_joy_scan;

    localparam int unsigned SETTLE = 4;
    localparam int unsigned DEB    = 3;
    localparam int unsigned PERIOD = 2 * (SETTLE + 1);

    logic       pclk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] p1_in, p2_in;
    logic [7:0] jjoy;
    logic [1:0] jcoin;
    logic       jservice, jtest;
    logic [5:0] kbd_joy;
    logic       jselect;
    logic [7:0] joystick1, joystick2;
    logic [1:0] coin;
    logic       service, test, scan_tick;

    jamma_joy_scan #(.SETTLE(SETTLE), .DEB_SAMPLES(DEB)) dut (
        .pclk      (pclk),
        .reset     (reset),
        .jjoy      (jjoy),
        .jcoin     (jcoin),
        .jservice  (jservice),
        .jtest     (jtest),
        .kbd_joy   (kbd_joy),
        .jselect   (jselect),
        .joystick1 (joystick1),
        .joystick2 (joystick2),
        .coin      (coin),
        .service   (service),
        .test      (test),
        .scan_tick (scan_tick)
    );

    // External board mux: jselect chooses which player drives the shared bus.
    assign jjoy = jselect ? p2_in : p1_in;

    always #5 pclk = ~pclk;

    // Cycle index since the last cycle in which reset was sampled high.
    int unsigned cyc = 0;
    always @(posedge pclk) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    typedef struct packed {
        logic [7:0] j1;
        logic [7:0] j2;
        logic [1:0] coin;
        logic       svc;
        logic       tst;
    } exp_t;

    exp_t       q_scan[$];
    logic [7:0] q_p1[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    logic       mon_en   = 1'b0;

    // Reference model: 20 output bits {tst, svc, coin[1:0], p2[7:0], p1[7:0]}.
    // A bit takes a new value once the last DEB scans all disagreed with it.
    logic [19:0] m_out;
    logic [19:0] m_hist[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_out = '1;
        m_hist.delete();
    endtask

    task automatic model_scan(input logic [19:0] samp);
        bit all_differ;
        m_hist.push_back(samp);
        if (m_hist.size() > DEB) void'(m_hist.pop_front());
        if (m_hist.size() == DEB) begin
            for (int b = 0; b < 20; b++) begin
                all_differ = 1'b1;
                foreach (m_hist[k]) if (m_hist[k][b] == m_out[b]) all_differ = 1'b0;
                if (all_differ) m_out[b] = ~m_out[b];
            end
        end
    endtask

    // Drive one scan's worth of stable inputs, predict, then let it run.
    task automatic apply_scan(input logic [7:0] p1, input logic [7:0] p2, input logic [1:0] cn,
                              input logic sv, input logic ts, input logic [5:0] kb,
                              input int unsigned wait_cycles);
        exp_t e;
        p1_in    = p1;
        p2_in    = p2;
        jcoin    = cn;
        jservice = sv;
        jtest    = ts;
        kbd_joy  = kb;
        model_scan({ts, sv, cn, p2, p1 & {2'b11, kb}});
        e.j1   = m_out[7:0];
        e.j2   = m_out[15:8];
        e.coin = m_out[17:16];
        e.svc  = m_out[18];
        e.tst  = m_out[19];
        q_p1.push_back(m_out[7:0]);
        q_scan.push_back(e);
        repeat (wait_cycles) @(negedge pclk);
    endtask

    task automatic check_reset_outputs();
        check("rst_joystick1", 32'(joystick1), 32'hFF);
        check("rst_joystick2", 32'(joystick2), 32'hFF);
        check("rst_coin",      32'(coin),      32'h3);
        check("rst_service",   32'(service),   32'h1);
        check("rst_test",      32'(test),      32'h1);
        check("rst_scan_tick", 32'(scan_tick), 32'h0);
        check("rst_jselect",   32'(jselect),   32'h0);
    endtask

    // Monitor: per-cycle jselect/tick framing, scoreboard pops on tick and on the cycle after P1.
    always @(negedge pclk) begin
        if (mon_en) begin
            check("jselect", 32'(jselect), 32'((cyc % PERIOD) >= SETTLE + 1));
            check("scan_tick", 32'(scan_tick), 32'((cyc > 0) && (cyc % PERIOD == 0)));
            if (scan_tick) begin
                if (q_scan.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL tick_without_scan: got tick expected none at t=%0t", $time);
                end else begin
                    exp_t e;
                    e = q_scan.pop_front();
                    check("joystick1", 32'(joystick1), 32'(e.j1));
                    check("joystick2", 32'(joystick2), 32'(e.j2));
                    check("coin",      32'(coin),      32'(e.coin));
                    check("service",   32'(service),   32'(e.svc));
                    check("test",      32'(test),      32'(e.tst));
                end
            end
            if (cyc % PERIOD == SETTLE + 1) begin
                if (q_p1.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL p1_without_scan: got P1 edge expected none at t=%0t", $time);
                end else begin
                    check("joystick1_after_p1", 32'(joystick1), 32'(q_p1.pop_front()));
                end
            end
        end
    end

    initial begin
        logic [7:0] r_p1, r_p2;
        logic [1:0] r_cn;
        logic       r_sv, r_ts;
        logic [5:0] r_kb;

        p1_in = 8'hFF; p2_in = 8'hFF; jcoin = 2'b11;
        jservice = 1'b1; jtest = 1'b1; kbd_joy = 6'h3F;
        model_reset();

        // Reset held for 5 cycles.
        reset = 1'b1;
        repeat (5) begin
            @(negedge pclk);
            check_reset_outputs();
        end
        reset  = 1'b0;
        mon_en = 1'b1;

        // Idle scans: framing only.
        repeat (2) apply_scan(8'hFF, 8'hFF, 2'b11, 1'b1, 1'b1, 6'h3F, PERIOD);

        // Player 1 bit0 press.
        repeat (4) apply_scan(8'hFE, 8'hFF, 2'b11, 1'b1, 1'b1, 6'h3F, PERIOD);
        repeat (3) apply_scan(8'hFF, 8'hFF, 2'b11, 1'b1, 1'b1, 6'h3F, PERIOD);

        // Player 2 bit4 glitch of 2 scans, then a real 3-scan press.
        repeat (2) apply_scan(8'hFF, 8'hEF, 2'b11, 1'b1, 1'b1, 6'h3F, PERIOD);
        repeat (1) apply_scan(8'hFF, 8'hFF, 2'b11, 1'b1, 1'b1, 6'h3F, PERIOD);
        repeat (3) apply_scan(8'hFF, 8'hEF, 2'b11, 1'b1, 1'b1, 6'h3F, PERIOD);
        repeat (3) apply_scan(8'hFF, 8'hFF, 2'b11, 1'b1, 1'b1, 6'h3F, PERIOD);

        // Keyboard merge into player 1.
        repeat (4) apply_scan(8'hFF, 8'hFF, 2'b11, 1'b1, 1'b1, 6'b111011, PERIOD);
        repeat (3) apply_scan(8'hFF, 8'hFF, 2'b11, 1'b1, 1'b1, 6'h3F, PERIOD);

        // Coin pulse and release.
        repeat (5) apply_scan(8'hFF, 8'hFF, 2'b10, 1'b1, 1'b1, 6'h3F, PERIOD);
        repeat (4) apply_scan(8'hFF, 8'hFF, 2'b11, 1'b1, 1'b1, 6'h3F, PERIOD);

        // Service/test lines.
        repeat (3) apply_scan(8'hFF, 8'hFF, 2'b11, 1'b0, 1'b0, 6'h3F, PERIOD);
        repeat (3) apply_scan(8'hFF, 8'hFF, 2'b11, 1'b1, 1'b1, 6'h3F, PERIOD);

        // Settle joystick1 to 00, then reset for one cycle inside S2.
        repeat (4) apply_scan(8'h00, 8'hFF, 2'b11, 1'b1, 1'b1, 6'h3F, PERIOD);
        apply_scan(8'h00, 8'hFF, 2'b11, 1'b1, 1'b1, 6'h3F, SETTLE + 2);
        reset = 1'b1;
        q_scan.delete();
        q_p1.delete();
        model_reset();
        @(negedge pclk);
        check_reset_outputs();
        reset = 1'b0;
        repeat (4) apply_scan(8'h00, 8'hFF, 2'b11, 1'b1, 1'b1, 6'h3F, PERIOD);

        // Randomised scans with sticky values so debounced flips happen.
        r_p1 = 8'hFF; r_p2 = 8'hFF; r_cn = 2'b11; r_sv = 1'b1; r_ts = 1'b1; r_kb = 6'h3F;
        for (int s = 0; s < 60; s++) begin
            if ($urandom_range(3) == 0) r_p1 = 8'($urandom);
            if ($urandom_range(3) == 0) r_p2 = 8'($urandom);
            if ($urandom_range(3) == 0) r_cn = 2'($urandom);
            if ($urandom_range(4) == 0) r_sv = 1'($urandom);
            if ($urandom_range(4) == 0) r_ts = 1'($urandom);
            if ($urandom_range(5) == 0) r_kb = 6'($urandom);
            apply_scan(r_p1, r_p2, r_cn, r_sv, r_ts, r_kb, PERIOD);
        end

        // Let the last tick be consumed, then confirm nothing is left outstanding.
        repeat (2) @(negedge pclk);
        mon_en = 1'b0;
        check("pending_scans", 32'(q_scan.size()), 32'h0);
        check("pending_p1",    32'(q_p1.size()),   32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/jamma_joy_scan.md
# jamma_joy_scan

Time-multiplexed JAMMA control scanner for the Sprint 2 colour build. Drives the external `JSELECT` line and alternately samples the shared 8-bit `JJOY` bus as player 1 and player 2. It also samples the coin, service and test lines and debounces every input. It sits between the board pins and the `sprint2` core, which it feeds with clean, active-low `joystick1`, `joystick2` and coin levels, plus a per-scan tick.

## Interface
Parameters:
- `SETTLE`, default 4: cycles spent in each settle state after `jselect` changes. Legal range 3..255; 3 is the minimum so the 2-FF synchroniser sees post-switch data.
- `DEB_SAMPLES`, default 3: consecutive disagreeing samples needed before an output bit flips. Legal range 1..15.

Ports:
- `pclk`, in, 1: pixel clock; the only clock.
- `reset`, in, 1: synchronous, active-high.
- `jjoy`, in, 8: JAMMA joystick bus, active-low, asynchronous.
- `jcoin`, in, 2: coin switches, active-low, asynchronous.
- `jservice`, in, 1: service switch, active-low, asynchronous.
- `jtest`, in, 1: test switch, active-low, asynchronous.
- `kbd_joy`, in, 6: keyboard joystick, active-low, synchronous to `pclk`. ANDed into player 1 bits 5:0 only.
- `jselect`, out, 1: bus select; 0 = player 1, 1 = player 2.
- `joystick1`, out, 8: debounced player 1 controls, active-low.
- `joystick2`, out, 8: debounced player 2 controls, active-low.
- `coin`, out, 2: debounced coin levels, active-low.
- `service`, out, 1: debounced service level, active-low.
- `test`, out, 1: debounced test level, active-low.
- `scan_tick`, out, 1: one-cycle pulse after each complete scan.

## Operation
- **Synchroniser:** `jjoy`, `jcoin`, `jservice` and `jtest` each pass through a 2-FF synchroniser every cycle.
- **Scan FSM:** four states, looping S1 → P1 → S2 → P2 → S1.
  - `S1` (settle P1): `jselect`=0; count up to `SETTLE` cycles.
  - `P1` (sample P1): `jselect`=0; one cycle.
  - `S2` (settle P2): `jselect`=1; count up to `SETTLE` cycles.
  - `P2` (sample P2): `jselect`=1; one cycle.
- **`jselect`:** registered and decoded from the state; it changes on the edge that enters `S2` or `S1`.
- **P1 sample:** sampled value = `sync(jjoy) & {2'b11, kbd_joy}`; it updates the 8 player-1 debounce cells.
- **P2 sample:** sampled value = `sync(jjoy)`; it updates the 8 player-2 cells and the 4 cells for coin[1:0], service and test.
- **Debounce cell:** one per output bit (20 total), each with a 4-bit counter.
  - Sample equals output: counter ← 0.
  - Sample differs and counter = `DEB_SAMPLES`−1: output ← sample, counter ← 0.
  - Sample differs otherwise: counter ← counter+1.
- **Reset:** takes priority over all other logic.
  - FSM → `S1`, settle counter 0.
  - All debounce counters 0 and synchroniser flops at 1.
  - `jselect`=0, `joystick1`=`joystick2`=8'hFF, `coin`=2'b11, `service`=1, `test`=1, `scan_tick`=0.
- **Reset mid-scan:** same result from any state; any partial debounce progress is discarded.

## Timing
- **Scan period:** 2·(`SETTLE`+1) cycles; 10 cycles at the defaults.
- **After reset release (cycle 0 = first cycle with `reset` low):**
  - `jselect` is 0 for cycles 0..`SETTLE`.
  - `jselect` is 1 for cycles `SETTLE`+1..2·`SETTLE`+1.
  - The pattern then repeats.
- **Sample edges:** player-1 cells update on the edge closing cycle `SETTLE`; player-2 and misc cells update on the edge closing cycle 2·`SETTLE`+1.
- **Output latency:** an output flips on the sample edge of the `DEB_SAMPLES`-th consecutive disagreeing scan, so it is visible in the following cycle.
- **`scan_tick`:** high exactly one cycle, the cycle after each P2 sample edge (cycle 2·`SETTLE`+2 mod period). It aligns with fresh player-2 and misc outputs.
- **Simultaneous change:** an input changing during a settle state is harmless. Only the synchronised value at the sample edge matters.

## Test plan
Bench settings: `SETTLE`=4, `DEB_SAMPLES`=3, scan period 10 cycles. The bench models the external mux from `jselect`.

1. **Reset:** hold reset 5 cycles, then release, with all inputs 1.
   - Outputs must be FF, FF, 11, 1, 1 and `scan_tick`=0 during reset.
   - `jselect` must follow 0×5, 1×5, repeating.
   - `scan_tick` must pulse at cycles 10, 20, …
2. **Player 1 press:** drive player-1 bit0=0 while `jselect`=0; the player-2 view stays FF.
   - `joystick1` must equal 8'hFE from the cycle after the 3rd P1 sample edge.
   - `joystick2` must stay 8'hFF throughout.
3. **Glitch rejection:** hold player-2 bit4 low for 2 scans, then high.
   - `joystick2` must stay 8'hFF.
   - A following 3-scan press must flip it to 8'hEF.
4. **Keyboard merge:** `kbd_joy`=6'b111011 with `jjoy` idle.
   - `joystick1` must equal 8'hFB after 3 scans.
   - `joystick2` must stay 8'hFF.
5. **Coin:** `jcoin`=2'b10 for 5 scans, then 2'b11.
   - `coin` must be 2'b10 after the 3rd P2 sample.
   - `coin` must return to 2'b11 three scans after release.
6. **Reset mid-scan:** with `joystick1`=8'h00 settled, assert `reset` for 1 cycle during `S2`.
   - Next cycle: `joystick1`=8'hFF and `jselect`=0.
   - `joystick1` must re-settle to 8'h00 three scans after release.
